// File: rtl/pc_control_pkg.sv
// Shared encodings and constants for the pc_control front-end controller.
package pc_control_pkg;

  typedef enum logic [1:0] {
    PCC_IDLE       = 2'd0,
    PCC_FETCH_WAIT = 2'd1,
    PCC_TIMEOUT    = 2'd2
  } pcc_state_e;

  localparam logic [31:0] WORD_ZERO = 32'd0;
  localparam logic [4:0]  REG_ZERO  = 5'd0;

endpackage

// File: rtl/pc_control_load_use_detect.sv
// Combinational load-use hazard detector: flags an ID instruction reading the
// destination of a load currently in EX.
module load_use_detect
  import pc_control_pkg::*;
(
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  output logic       lu
);

  logic rs_match;
  logic rt_match;

  // Register zero is hardwired, so a load targeting it never creates a hazard.
  assign rs_match = (ex_rt == id_rs);
  assign rt_match = id_uses_rt && (ex_rt == id_rt);
  assign lu       = ex_mem_read && (ex_rt != REG_ZERO) && (rs_match || rt_match);

endmodule

// File: rtl/pc_control.sv
// Front-end stall/flush controller: merges load-use, redirect and fetch-wait
// hazards into PC / IF-ID / ID-EX controls. Perf counters: PC_CONTROL_PERF_EN.
module pc_control
  import pc_control_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             redirect,
  input  logic             imem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] redirect_count
);

  localparam int WCNT_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [WCNT_W-1:0] WAIT_LIMIT = WCNT_W'(WAIT_MAX);

  pcc_state_e        state_q, state_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout_q, timeout_d;
  logic              lu;
  logic              wait_hit;
  logic [WCNT_W-1:0] wait_inc;

  load_use_detect u_load_use_detect (
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .lu          (lu)
  );

  assign wait_hit = (wait_cnt_q == WAIT_LIMIT);
  assign wait_inc = wait_hit ? wait_cnt_q : wait_cnt_q + WCNT_W'(1);

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    timeout_d   = timeout_q;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;

    if (state_q == PCC_TIMEOUT) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (redirect) begin
      // The outstanding fetch is abandoned; the new one starts a fresh wait.
      if_id_flush = 1'b1;
      wait_cnt_d  = '0;
      state_d     = imem_ready ? PCC_IDLE : PCC_FETCH_WAIT;
    end else if (lu) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
      if (!imem_ready) begin
        if (wait_hit) begin
          state_d   = PCC_TIMEOUT;
          timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_inc;
        end
      end
    end else if (!imem_ready) begin
      pc_write    = 1'b0;
      if_id_flush = 1'b1;
      if (wait_hit) begin
        state_d   = PCC_TIMEOUT;
        timeout_d = 1'b1;
      end else begin
        state_d    = PCC_FETCH_WAIT;
        wait_cnt_d = wait_inc;
      end
    end else begin
      state_d    = PCC_IDLE;
      wait_cnt_d = '0;
    end

    // Reset holds the whole front end frozen with bubbles in both stages.
    if (rst) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= PCC_IDLE;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign timeout = timeout_q;

`ifdef PC_CONTROL_PERF_EN
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] redirect_count_q, redirect_count_d;

  // Only redirects seen outside TIMEOUT are accepted and counted.
  always_comb begin
    stall_cycles_d   = stall_cycles_q;
    redirect_count_d = redirect_count_q;
    if (!pc_write) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
    if (redirect && (state_q != PCC_TIMEOUT)) begin
      redirect_count_d = redirect_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q   <= '0;
      redirect_count_q <= '0;
    end else begin
      stall_cycles_q   <= stall_cycles_d;
      redirect_count_q <= redirect_count_d;
    end
  end

  assign stall_cycles   = stall_cycles_q;
  assign redirect_count = redirect_count_q;
`else
  assign stall_cycles   = CNT_W'(WORD_ZERO);
  assign redirect_count = CNT_W'(WORD_ZERO);
`endif

endmodule

// File: tb/tb_pc_control.sv
// Directed self-checking bench for pc_control; tracks perf counters when
// PC_CONTROL_PERF_EN is defined, otherwise expects them tied to zero.
module tb_pc_control;

  localparam int CNT_W = 32;
`ifdef PC_CONTROL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             ex_mem_read;
  logic [4:0]       ex_rt;
  logic             redirect;
  logic             imem_ready;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] redirect_count;

  int               n_cmp;
  int               n_fail;
  logic [CNT_W-1:0] exp_stall;
  logic [CNT_W-1:0] exp_redir;
  logic             exp_timeout;
  bit               pend_stall;
  bit               pend_redir;

  pc_control #(.WAIT_MAX(15), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_uses_rt     (id_uses_rt),
    .ex_mem_read    (ex_mem_read),
    .ex_rt          (ex_rt),
    .redirect       (redirect),
    .imem_ready     (imem_ready),
    .pc_write       (pc_write),
    .if_id_write    (if_id_write),
    .if_id_flush    (if_id_flush),
    .id_ex_flush    (id_ex_flush),
    .timeout        (timeout),
    .stall_cycles   (stall_cycles),
    .redirect_count (redirect_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Compares all outputs against expectations, then records which counter
  // events the DUT should commit at the coming clock edge.
  task automatic checkOutput(input string tag, input logic e_pw, input logic e_iw,
                             input logic e_if, input logic e_ef, input bit redir_acc);
    cmp({tag, ".pc_write"},    64'(pc_write),    64'(e_pw));
    cmp({tag, ".if_id_write"}, 64'(if_id_write), 64'(e_iw));
    cmp({tag, ".if_id_flush"}, 64'(if_id_flush), 64'(e_if));
    cmp({tag, ".id_ex_flush"}, 64'(id_ex_flush), 64'(e_ef));
    cmp({tag, ".timeout"},     64'(timeout),     64'(exp_timeout));
    cmp({tag, ".stall_cycles"},   64'(stall_cycles),   64'(PERF ? exp_stall : '0));
    cmp({tag, ".redirect_count"}, 64'(redirect_count), 64'(PERF ? exp_redir : '0));
    pend_stall = !e_pw && !rst;
    pend_redir = redir_acc && !rst;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (pend_stall) exp_stall++;
    if (pend_redir) exp_redir++;
    pend_stall = 1'b0;
    pend_redir = 1'b0;
  endtask

  task automatic applyStimulus(input logic rd, input logic rdy, input logic mr,
                               input logic [4:0] xrt, input logic [4:0] rs,
                               input logic [4:0] rt, input logic urt);
    redirect    = rd;
    imem_ready  = rdy;
    ex_mem_read = mr;
    ex_rt       = xrt;
    id_rs       = rs;
    id_rt       = rt;
    id_uses_rt  = urt;
    #1;
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    exp_stall = '0; exp_redir = '0; exp_timeout = 1'b0;
    pend_stall = 1'b0; pend_redir = 1'b0;
    rst = 1'b1;
    applyStimulus(0, 1, 0, 5'd0, 5'd0, 5'd0, 0);

    $display("[TB] reset");
    for (int i = 0; i < 3; i++) begin
      checkOutput("reset", 0, 0, 1, 1, 0);
      tick();
    end
    rst = 1'b0;
    applyStimulus(0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
    checkOutput("post_reset", 1, 1, 0, 0, 0);
    tick();

    $display("[TB] load-use");
    applyStimulus(0, 1, 1, 5'd5, 5'd5, 5'd0, 0);
    checkOutput("lu_rs", 0, 0, 0, 1, 0);
    tick();
    applyStimulus(0, 1, 1, 5'd0, 5'd0, 5'd0, 1);
    checkOutput("lu_r0", 1, 1, 0, 0, 0);
    tick();
    applyStimulus(0, 1, 1, 5'd7, 5'd3, 5'd7, 1);
    checkOutput("lu_rt", 0, 0, 0, 1, 0);
    tick();
    applyStimulus(0, 1, 1, 5'd7, 5'd3, 5'd7, 0);
    checkOutput("lu_rt_unused", 1, 1, 0, 0, 0);
    tick();

    $display("[TB] fetch wait");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
      checkOutput("fetch_wait", 0, 1, 1, 0, 0);
      tick();
    end
    applyStimulus(0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
    checkOutput("fetch_done", 1, 1, 0, 0, 0);
    tick();

    $display("[TB] redirect during wait, then timeout");
    applyStimulus(0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    checkOutput("wait1", 0, 1, 1, 0, 0);
    tick();
    applyStimulus(1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    checkOutput("redir_wait", 1, 1, 1, 0, 1);
    tick();
    for (int i = 0; i < 15; i++) begin
      applyStimulus(0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
      checkOutput("wait_post_redir", 0, 1, 1, 0, 0);
      tick();
    end
    applyStimulus(0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    checkOutput("wait_16", 0, 1, 1, 0, 0);
    tick();
    exp_timeout = 1'b1;
    applyStimulus(1, 1, 1, 5'd5, 5'd5, 5'd0, 0);
    checkOutput("timeout_redir", 0, 0, 1, 1, 0);
    tick();
    applyStimulus(0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
    checkOutput("timeout_idle_in", 0, 0, 1, 1, 0);
    tick();

    $display("[TB] async reset out of timeout");
    rst = 1'b1;
    #1;
    exp_timeout = 1'b0;
    exp_stall = '0;
    exp_redir = '0;
    checkOutput("async_rst", 0, 0, 1, 1, 0);
    #1;
    rst = 1'b0;
    tick();
    applyStimulus(0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
    checkOutput("after_rst", 1, 1, 0, 0, 0);
    tick();

    $display("[TB] simultaneous events");
    applyStimulus(1, 1, 1, 5'd5, 5'd5, 5'd0, 0);
    checkOutput("redir_lu", 1, 1, 1, 0, 1);
    tick();
    applyStimulus(0, 0, 1, 5'd9, 5'd9, 5'd0, 0);
    checkOutput("lu_not_ready", 0, 0, 0, 1, 0);
    tick();
    applyStimulus(0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
    checkOutput("final", 1, 1, 0, 0, 0);
    tick();
    checkOutput("final_counts", 1, 1, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
